// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci calculator/decoder family: state encoding,
// the first index of the sequence and a golden reference usable from benches.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } fib_index_state_t;

  // Indexing starts at F(1) = 0, F(2) = 1.
  localparam int FIB_FIRST_INDEX = 1;

  function automatic longint unsigned fib_ref(int idx);
    longint unsigned a = 64'd0;
    longint unsigned b = 64'd1;
    longint unsigned t;
    if (idx <= FIB_FIRST_INDEX) return 64'd0;
    for (int k = 2; k < idx; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

endpackage

// File: rtl/fib_index.sv
// Inverse Fibonacci: walks the sequence one index per cycle until the next term
// exceeds the captured value (or the index saturates) and reports the floor term.
module fib_index
  import fib_pkg::*;
#(
  parameter int VALUE_WIDTH = 64,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic [INDEX_WIDTH-1:0] n,
  output logic [VALUE_WIDTH-1:0] fib_floor,
  output logic                   is_fib,
  output logic                   index_overflow,
  output logic                   done
);

  localparam logic [INDEX_WIDTH-1:0] INDEX_MAX = '1;

  fib_index_state_t       state_q;
  logic [VALUE_WIDTH-1:0] v_q;
  logic [INDEX_WIDTH-1:0] i_q;
  logic [VALUE_WIDTH-1:0] x_q;
  logic [VALUE_WIDTH:0]   y_q;

  logic                   next_fits;
  logic                   at_max;
  logic [VALUE_WIDTH:0]   y_d;

  // Both terms are <= v_q whenever we add, so the sum fits in VALUE_WIDTH+1 bits.
  assign next_fits = (y_q <= {1'b0, v_q});
  assign at_max    = (i_q == INDEX_MAX);
  assign y_d       = y_q + {1'b0, x_q};

  // NOTE: every register here uses non-blocking assignments so all of them sample
  // pre-edge values; blocking assignments would make x_q/y_q see each other's updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      v_q            <= '0;
      i_q            <= '0;
      x_q            <= '0;
      y_q            <= '0;
      n              <= '0;
      fib_floor      <= '0;
      is_fib         <= 1'b0;
      index_overflow <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            v_q     <= value;
            i_q     <= INDEX_WIDTH'(FIB_FIRST_INDEX);
            x_q     <= '0;
            y_q     <= (VALUE_WIDTH+1)'(1);
            done    <= 1'b0;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (next_fits && !at_max) begin
            x_q <= y_q[VALUE_WIDTH-1:0];
            y_q <= y_d;
            i_q <= i_q + 1'b1;
          end else begin
            n              <= i_q;
            fib_floor      <= x_q;
            is_fib         <= (x_q == v_q);
            index_overflow <= next_fits;
            done           <= 1'b1;
            state_q        <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index.sv
// Randomized and directed bench for fib_index: a 64-bit/7-bit instance and a
// small 8-bit/3-bit instance, both compared against a direct search over fib_ref.
module tb_fib_index;
  import fib_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        go;
  logic [63:0] value;
  logic [6:0]  n;
  logic [63:0] fib_floor;
  logic        is_fib, index_overflow, done;

  logic        go3;
  logic [7:0]  value3;
  logic [2:0]  n3;
  logic [7:0]  fib3;
  logic        is_fib3, ov3, done3;

  int errors = 0;
  int checks = 0;

  fib_index #(.VALUE_WIDTH(64), .INDEX_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .go(go), .value(value), .n(n), .fib_floor(fib_floor),
    .is_fib(is_fib), .index_overflow(index_overflow), .done(done)
  );

  fib_index #(.VALUE_WIDTH(8), .INDEX_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .go(go3), .value(value3), .n(n3), .fib_floor(fib3),
    .is_fib(is_fib3), .index_overflow(ov3), .done(done3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Largest index whose term is <= v, capped at max_idx; F(95) exceeds 64 bits.
  task automatic ref_search(input longint unsigned v, input int max_idx,
                            output int en, output longint unsigned ef, output bit eov);
    en = 1;
    while (en < max_idx && en < 94 && fib_ref(en + 1) <= v) en++;
    ef  = fib_ref(en);
    eov = (en == max_idx) && (en < 94) && (fib_ref(en + 1) <= v);
  endtask

  task automatic run64(input logic [63:0] v, input bit disturb);
    int en, cyc;
    longint unsigned ef;
    bit eov;
    logic [6:0] old_n;
    ref_search(v, 127, en, ef, eov);
    @(negedge clk);
    old_n = n;
    go    = 1'b1;
    value = v;
    @(negedge clk);
    go = 1'b0;
    check("done_clear", done, 0);
    check("n_hold", n, old_n);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (disturb && cyc >= 2 && cyc <= en - 2) begin
        go    = 1'b1;
        value = {$urandom, $urandom};
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
    check("done_seen", done, 1);
    check("latency", cyc, en);
    check("n", n, en);
    check("fib_floor", fib_floor, ef);
    check("is_fib", is_fib, (ef == v));
    check("overflow", index_overflow, eov);
  endtask

  task automatic run8(input logic [7:0] v);
    int en, cyc;
    longint unsigned ef;
    bit eov;
    ref_search(64'(v), 7, en, ef, eov);
    @(negedge clk);
    go3    = 1'b1;
    value3 = v;
    @(negedge clk);
    go3 = 1'b0;
    check("done3_clear", done3, 0);
    cyc = 0;
    while (!done3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("done3_seen", done3, 1);
    check("latency3", cyc, en);
    check("n3", n3, en);
    check("fib3", fib3, ef);
    check("is_fib3", is_fib3, (ef == 64'(v)));
    check("overflow3", ov3, eov);
  endtask

  initial begin
    int cyc;
    rst    = 1'b0;
    go     = 1'b0;
    value  = '0;
    go3    = 1'b0;
    value3 = '0;
    #12;
    check("rst_n", n, 0);
    check("rst_fib", fib_floor, 0);
    check("rst_is_fib", is_fib, 0);
    check("rst_ovf", index_overflow, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases from the plan.
    run64(64'd0, 1'b0);
    check("v0_n", n, 1);
    check("v0_fib", fib_floor, 0);
    run64(64'd1, 1'b0);
    check("v1_n", n, 3);
    run64(64'd4, 1'b0);
    check("v4_n", n, 5);
    check("v4_fib", fib_floor, 3);
    run64(64'd5, 1'b0);
    check("v5_n", n, 6);
    check("v5_is_fib", is_fib, 1);
    run64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("vmax_n", n, 94);
    check("vmax_fib", fib_floor, 64'd12200160415121876738);
    run64(64'd50, 1'b1);
    check("v50_n", n, 10);
    check("v50_fib", fib_floor, 34);

    run8(8'd8);
    check("w3_v8_ovf", ov3, 0);
    run8(8'd13);
    check("w3_v13_n", n3, 7);
    check("w3_v13_ovf", ov3, 1);

    // go held high: done pulses one cycle, restarting every n+1 edges (value 4 -> n=5).
    @(negedge clk);
    go    = 1'b1;
    value = 64'd4;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      check("held_drop", done, 0);
      cyc = 1;
      while (!done && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("held_gap", cyc, 6);
    end
    go = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("held_settle", done, 1);

    // Reset mid-SEARCH clears everything without a clock edge.
    @(negedge clk);
    go    = 1'b1;
    value = 64'h8000_0000_0000_0000;
    @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_n", n, 0);
    check("mid_rst_fib", fib_floor, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ovf", index_overflow, 0);
    check("mid_rst_isfib", is_fib, 0);
    @(negedge clk);
    rst = 1'b1;

    // Sweep and random coverage.
    for (int v = 0; v <= 1000; v++) run64(64'(v), 1'b0);
    for (int r = 0; r < 30; r++) run64({$urandom, $urandom} >> $urandom_range(0, 63), 1'b0);
    for (int r = 0; r < 30; r++) run8(8'($urandom_range(0, 255)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fib_index.md
Name: fib_index

Overview:
Inverse Fibonacci unit, the decode direction of the team's Fibonacci calculator. Given an unsigned value, it iteratively finds the largest index n with F(n) <= value. It reports n, F(n), whether the value is exactly Fibonacci, and an index-overflow flag. It uses the same go/done handshake and the same indexing as the calculator: F(1)=0, F(2)=1, F(3)=1, F(4)=2, F(5)=3, and so on.

Parameters:
VALUE_WIDTH, 64, bit width of the value input and the fib_floor output.
INDEX_WIDTH, 7, bit width of the n output; must be at least 2.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous reset, active-low (asserted when 0).
go  in  1  start request; sampled only in IDLE or DONE.
value  in  VALUE_WIDTH  operand; captured only on an accepted go.
n  out  INDEX_WIDTH  largest index with F(n) <= value; valid while done=1.
fib_floor  out  VALUE_WIDTH  F(n); valid while done=1.
is_fib  out  1  1 when fib_floor == captured value; valid while done=1.
index_overflow  out  1  1 when the search stopped because the index hit its maximum; valid while done=1.
done  out  1  result valid.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0, including done. All internal registers are 0.
- States: IDLE, SEARCH, DONE.
- Internal registers:
  - v_r, VALUE_WIDTH: captured value.
  - i_r, INDEX_WIDTH: current index.
  - x_r, VALUE_WIDTH: holds F(i_r).
  - y_r, VALUE_WIDTH+1: holds F(i_r+1).
- IDLE or DONE with go=1:
  - v_r<=value, i_r<=1, x_r<=0, y_r<=1.
  - done<=0 on that same edge.
  - Next state is SEARCH.
- IDLE or DONE with go=0: hold. Outputs stay stable.
- SEARCH, advance case (y_r <= v_r and i_r != 2^INDEX_WIDTH-1):
  - x_r<=y_r, y_r<=x_r+y_r, i_r<=i_r+1.
  - y_r never exceeds 2^(VALUE_WIDTH+1)-1, because both x_r and y_r are <= v_r when adding.
- SEARCH, exit case (y_r > v_r):
  - n<=i_r, fib_floor<=x_r, is_fib<=(x_r==v_r), index_overflow<=0.
  - done<=1; next state is DONE.
- SEARCH, index-limit case (y_r <= v_r and i_r == 2^INDEX_WIDTH-1):
  - n<=i_r, fib_floor<=x_r, is_fib<=(x_r==v_r), index_overflow<=1.
  - done<=1; next state is DONE.
- Latency: with the go edge as E0, done rises at edge E0+n (one SEARCH cycle per index). For value=0, done rises at E0+1.
- go while in SEARCH is ignored; value changes during SEARCH are ignored.
- done stays 1 indefinitely in DONE. It clears on the edge that accepts the next go.
- n, fib_floor, is_fib and index_overflow hold their previous values until the next completion. They are not cleared on go.
- Duplicate Fibonacci value 1: F(2)=F(3)=1. value=1 returns n=3 (the largest index).
- go held high continuously: each completion is followed one edge later by a restart, so done pulses for one cycle per result.
- Reset mid-SEARCH: immediate return to the reset values; no partial result appears.
- Everything is unsigned; there are no X-propagating paths from unused inputs.

Decomposition:
- Package fib_pkg holds:
  - the fib_index_state_t enum (IDLE, SEARCH, DONE);
  - the constant FIB_FIRST_INDEX=1;
  - an automatic function fib_ref(int idx) returning longint unsigned, shared with the calculator benches as the golden model.
- Single flat module; no sub-module is warranted, since the datapath is one adder plus comparators.

Test Plan:
- Reset then value=0, go pulse -> done at E0+1, n=1, fib_floor=0, is_fib=1, index_overflow=0.
- value=1 -> n=3, fib_floor=1, is_fib=1, done at E0+3.
- value=4 -> n=5, fib_floor=3, is_fib=0. Then value=5 with go while done=1 -> done drops on the next edge, then n=6, fib_floor=5, is_fib=1.
- value=2^64-1 -> n=94, fib_floor=12200160415121876738, is_fib=0, index_overflow=0.
- INDEX_WIDTH=3, two cases:
  - value=8 -> n=7, fib_floor=8, is_fib=1, overflow=0.
  - value=13 -> n=7, fib_floor=8, is_fib=0, index_overflow=1.
- Robustness:
  - value=50: toggle go and change value mid-SEARCH -> result unaffected (n=10, fib_floor=34).
  - Assert rst mid-SEARCH -> all outputs 0 asynchronously.
  - Sweep value 0..1000 against fib_ref.
